// File: rtl/morse_guess_checker_pkg.sv
// morse_guess_checker_pkg: symbol, result and state encodings shared by the guess checker.
package morse_guess_checker_pkg;
   typedef enum logic [1:0] {SYM_NONE = 2'b00, SYM_DOT = 2'b01, SYM_LINE = 2'b11} sym_e;
   typedef enum logic [1:0] {RES_NEUTRAL = 2'b00, RES_CORRECT = 2'b01, RES_INCORRECT = 2'b10} res_e;
   typedef enum logic [1:0] {ST_IDLE, ST_GUESS, ST_WIN, ST_LOSE} state_e;
   // 2'b10 never appears as a real symbol, so it terminates a code like NONE
   function automatic sym_e norm_sym(logic [1:0] s);
      return (s == 2'b10) ? SYM_NONE : sym_e'(s);
   endfunction
   function automatic int tries_w(int max_tries);
      return (max_tries < 1) ? 1 : $clog2(max_tries + 1);
   endfunction
endpackage

// File: rtl/morse_guess_if.sv
// morse_guess_if: game-side bus between the Morse decoder/game top and the guess checker.
interface morse_guess_if import morse_guess_checker_pkg::*; #(
   parameter int SYMBOLS   = 5,
   parameter int MAX_TRIES = 3
);
   localparam int TW = tries_w(MAX_TRIES);
   logic                 start;
   logic [2*SYMBOLS-1:0] secret;
   logic                 ld_dot;
   logic                 ld_line;
   logic [2*SYMBOLS-1:0] q;
   logic [1:0]           correct;
   logic [TW-1:0]        tries_left;
   logic                 busy;
   logic                 complete;
   logic                 failed;
   modport master (output start, secret, ld_dot, ld_line,
                   input  q, correct, tries_left, busy, complete, failed);
   modport slave  (input  start, secret, ld_dot, ld_line,
                   output q, correct, tries_left, busy, complete, failed);
endinterface

// File: rtl/morse_idle_timer.sv
// morse_idle_timer: counts enabled idle cycles and pulses expire on the TIMEOUT_CYC-th one.
module morse_idle_timer #(
   parameter int TIMEOUT_CYC = 50_000_000,
   parameter int CNT_W       = 26
) (
   input  logic clock,
   input  logic resetn,
   input  logic en,
   input  logic clr,
   output logic expire
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb begin
      expire = en && !clr && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
      cnt_d  = (!en || clr || expire) ? '0 : cnt_q + 1'b1;
   end
   always_ff @(posedge clock) begin
      if (!resetn) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/morse_guess_checker.sv
// morse_guess_checker: checks decoded Morse symbols against a latched secret code,
// with limited attempts, an idle timeout and explicit WIN/LOSE states.
module morse_guess_checker import morse_guess_checker_pkg::*; #(
   parameter int SYMBOLS     = 5,
   parameter int MAX_TRIES   = 3,
   parameter int TIMEOUT_CYC = 50_000_000,
   parameter int CNT_W       = 26
) (
   input  logic          clock,
   input  logic          resetn,
   morse_guess_if.slave  bus
);
   localparam int TW = tries_w(MAX_TRIES);
   localparam int IW = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;
   localparam int W  = 2 * SYMBOLS;
   state_e        state_q, state_d;
   res_e          correct_q, correct_d;
   logic [W-1:0]  secret_q, secret_d, q_q, q_d, cur_sh, nxt_sh;
   logic [TW-1:0] tries_q, tries_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          ev, expire, last;
   sym_e          ev_sym, cur;
   assign ev = bus.ld_dot ^ bus.ld_line;
   morse_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) u_timer (
      .clock  (clock),
      .resetn (resetn),
      .en     (state_q == ST_GUESS),
      .clr    (ev || bus.start),
      .expire (expire)
   );
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         correct_q <= RES_NEUTRAL;
         secret_q  <= '0;
         q_q       <= '0;
         tries_q   <= TW'(MAX_TRIES);
         idx_q     <= '0;
      end else begin
         state_q   <= state_d;
         correct_q <= correct_d;
         secret_q  <= secret_d;
         q_q       <= q_d;
         tries_q   <= tries_d;
         idx_q     <= idx_d;
      end
   end
   // an out-of-range shift on the final symbol yields zero, which reads as NONE
   always_comb begin
      cur_sh    = secret_q >> (2 * (SYMBOLS - 1 - int'(idx_q)));
      nxt_sh    = secret_q >> (2 * (SYMBOLS - 2 - int'(idx_q)));
      cur       = norm_sym(cur_sh[1:0]);
      last      = (int'(idx_q) == SYMBOLS - 1) || (norm_sym(nxt_sh[1:0]) == SYM_NONE);
      ev_sym    = bus.ld_dot ? SYM_DOT : SYM_LINE;
      state_d   = state_q;
      correct_d = RES_NEUTRAL;
      secret_d  = secret_q;
      q_d       = q_q;
      tries_d   = tries_q;
      idx_d     = idx_q;
      if (bus.start) begin
         state_d  = ST_GUESS;
         secret_d = bus.secret;
         q_d      = '0;
         tries_d  = TW'(MAX_TRIES);
         idx_d    = '0;
      end else if (state_q == ST_GUESS) begin
         if (cur == SYM_NONE) begin
            state_d = ST_WIN;
         end else if (ev && ev_sym == cur) begin
            q_d       = {q_q[W-3:0], ev_sym};
            idx_d     = last ? idx_q : idx_q + 1'b1;
            correct_d = RES_CORRECT;
            state_d   = last ? ST_WIN : ST_GUESS;
         end else if (ev || expire) begin
            q_d       = '0;
            idx_d     = '0;
            correct_d = RES_INCORRECT;
            tries_d   = (tries_q == '0) ? '0 : tries_q - 1'b1;
            state_d   = (tries_q <= TW'(1)) ? ST_LOSE : ST_GUESS;
         end
      end
   end
   always_comb begin
      bus.q          = q_q;
      bus.correct    = correct_q;
      bus.tries_left = tries_q;
      bus.busy       = state_q == ST_GUESS;
      bus.complete   = state_q == ST_WIN;
      bus.failed     = state_q == ST_LOSE;
   end
endmodule

// File: tb/tb_morse_guess_checker.sv
// tb_morse_guess_checker: directed game scenarios plus random play, checked every cycle
// against a queue-based model of the guessing game.
module tb_morse_guess_checker;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   always #5 clk = ~clk;
   morse_guess_if #(.SYMBOLS(5), .MAX_TRIES(3)) bus ();
   morse_guess_checker #(.SYMBOLS(5), .MAX_TRIES(3), .TIMEOUT_CYC(16), .CNT_W(5)) dut (
      .clock  (clk),
      .resetn (resetn),
      .bus    (bus)
   );
   // model: state 0 idle, 1 guessing, 2 won, 3 lost; code holds symbols before the terminator
   int m_code[$];
   int m_guess[$];
   int m_state, m_tries, m_idle, m_correct;
   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic int exp_q();
      int v = 0;
      foreach (m_guess[i]) v = ((v << 2) | m_guess[i]) & 'h3ff;
      return v;
   endfunction
   task automatic miss();
      m_guess.delete();
      m_correct = 2;
      if (m_tries > 0) m_tries--;
      if (m_tries == 0) m_state = 3;
   endtask
   task automatic model(input bit rst, input bit st, input bit d, input bit l, input logic [9:0] sec);
      int s;
      m_correct = 0;
      if (rst) begin
         m_state = 0; m_tries = 3; m_idle = 0;
         m_guess.delete(); m_code.delete();
      end else if (st) begin
         m_code.delete();
         for (int i = 0; i < 5; i++) begin
            s = int'(sec >> (8 - 2 * i)) & 3;
            if (s == 0 || s == 2) break;
            m_code.push_back(s);
         end
         m_guess.delete();
         m_tries = 3; m_idle = 0; m_state = 1;
      end else if (m_state == 1) begin
         if (m_code.size() == 0) m_state = 2;
         else if (d != l) begin
            m_idle = 0;
            s = d ? 1 : 3;
            if (s == m_code[m_guess.size()]) begin
               m_guess.push_back(s);
               m_correct = 1;
               if (m_guess.size() == m_code.size()) m_state = 2;
            end else miss();
         end else if (m_idle == 15) begin
            m_idle = 0;
            miss();
         end else m_idle++;
      end
   endtask
   task automatic cyc(input bit st, input bit d, input bit l, input bit rst = 1'b0);
      @(negedge clk);
      resetn = !rst; bus.start = st; bus.ld_dot = d; bus.ld_line = l;
      @(posedge clk);
      model(rst, st, d, l, bus.secret);
      #1;
      check("q", int'(bus.q), exp_q());
      check("correct", int'(bus.correct), m_correct);
      check("tries_left", int'(bus.tries_left), m_tries);
      check("busy", int'(bus.busy), int'(m_state == 1));
      check("complete", int'(bus.complete), int'(m_state == 2));
      check("failed", int'(bus.failed), int'(m_state == 3));
   endtask
   function automatic logic [9:0] rand_secret();
      logic [9:0] v = '0;
      int r;
      for (int i = 0; i < 5; i++) begin
         r = $urandom_range(0, 99);
         v = {v[7:0], (r < 4) ? 2'b00 : (r < 7) ? 2'b10 : (r < 53) ? 2'b01 : 2'b11};
      end
      return v;
   endfunction
   initial begin
      int r, s;
      bus.start = 1'b0; bus.ld_dot = 1'b0; bus.ld_line = 1'b0; bus.secret = '0;
      cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
      check("rst_tries", int'(bus.tries_left), 3);
      check("rst_correct", int'(bus.correct), 0);
      // correct dot-line-dot wins on the third symbol
      bus.secret = 10'b01_11_01_00_00;
      cyc(1, 0, 0); cyc(0, 1, 0); cyc(0, 0, 1); cyc(0, 1, 0);
      check("t1_q", int'(bus.q), 'b00_00_01_11_01);
      check("t1_complete", int'(bus.complete), 1);
      check("t1_busy", int'(bus.busy), 0);
      // wrong first symbol costs a try, then a correct replay wins
      cyc(1, 0, 0); cyc(0, 0, 1);
      check("t2_incorrect", int'(bus.correct), 2);
      check("t2_tries", int'(bus.tries_left), 2);
      cyc(0, 1, 0); cyc(0, 0, 1); cyc(0, 1, 0);
      check("t2_complete", int'(bus.complete), 1);
      // three misses lose; later symbols are ignored
      cyc(1, 0, 0); cyc(0, 0, 1); cyc(0, 0, 1); cyc(0, 0, 1);
      check("t3_failed", int'(bus.failed), 1);
      check("t3_tries", int'(bus.tries_left), 0);
      cyc(0, 1, 0);
      check("t3_q", int'(bus.q), 0);
      // idle timeout counts as a miss; simultaneous dot+line is ignored
      cyc(1, 0, 0);
      repeat (16) cyc(0, 0, 0);
      check("t4_timeout", int'(bus.correct), 2);
      check("t4_tries", int'(bus.tries_left), 2);
      cyc(0, 1, 1);
      check("t4_both", int'(bus.correct), 0);
      // empty secret wins with no input; all-line secret needs five lines
      bus.secret = '0;
      cyc(1, 0, 0); cyc(0, 0, 0);
      check("t5_empty_win", int'(bus.complete), 1);
      bus.secret = 10'b11_11_11_11_11;
      cyc(1, 0, 0);
      repeat (4) cyc(0, 0, 1);
      check("t5_not_yet", int'(bus.complete), 0);
      cyc(0, 0, 1);
      check("t5_lines_win", int'(bus.complete), 1);
      // reset mid-guess, and restart mid-guess after a miss
      cyc(1, 0, 0); cyc(0, 0, 1); cyc(0, 0, 1); cyc(0, 0, 0, 1);
      check("t6_rst_q", int'(bus.q), 0);
      check("t6_rst_busy", int'(bus.busy), 0);
      cyc(1, 0, 0); cyc(0, 1, 0); cyc(1, 0, 0);
      check("t6_restart_tries", int'(bus.tries_left), 3);
      check("t6_restart_busy", int'(bus.busy), 1);
      for (int k = 0; k < 3000; k++) begin
         r = $urandom_range(0, 99);
         if (r < 5) begin
            bus.secret = rand_secret();
            cyc(1, 0, 0);
         end else if (r < 6) cyc(0, 0, 0, 1);
         else if (r < 10) cyc(0, 1, 1);
         else if (r < 40) cyc(0, 0, 0);
         else begin
            s = ($urandom_range(0, 1) != 0) ? 3 : 1;
            if (m_state == 1 && m_guess.size() < m_code.size() && $urandom_range(0, 3) != 0)
               s = m_code[m_guess.size()];
            cyc(0, s == 1, s == 3);
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
